// File: rtl/bsort_ctrl_if.sv
// rtl/bsort_ctrl_if.sv - controller-to-datapath handshake and strobe bundle
// in_valid/in_ready/wr_en : load stream into arr[addr]
// cmp_gt/swap_en          : compare arr[addr] > arr[addr+1], swap strobe
// out_valid/out_ready     : unload stream of arr[addr]
// addr                    : shared array index
interface bsort_ctrl_if #(
    parameter int AW = 4
) ();
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic          cmp_gt;
    logic          swap_en;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] addr;

    modport master (
        input  in_valid, cmp_gt, out_ready,
        output in_ready, wr_en, swap_en, out_valid, addr
    );

    modport slave (
        output in_valid, cmp_gt, out_ready,
        input  in_ready, wr_en, swap_en, out_valid, addr
    );
endinterface

// File: rtl/bsort_ctrl.sv
// rtl/bsort_ctrl.sv - bubble-sort sequencing controller (load, compare passes, unload)
// clk, rst     : clock, asynchronous active-high reset
// start        : job request, sampled in IDLE only
// dp           : datapath handshake/strobe bundle (master side)
// busy         : high in LOAD, CMP, UNLOAD
// sorting_done : one-cycle pulse after the last unload beat
// cycle_count  : busy cycles of the last/current job, saturating
// pass_count   : compare passes of the last/current job, saturating
module bsort_ctrl #(
    parameter int SIZE = 15,
    parameter int AW   = 4,
    parameter int CW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    bsort_ctrl_if.master    dp,
    output logic            busy,
    output logic            sorting_done,
    output logic [CW-1:0]   cycle_count,
    output logic [AW-1:0]   pass_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CMP,
        S_UNLOAD,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(SIZE - 1);
    localparam logic [CW-1:0] CYC_MAX  = {CW{1'b1}};
    localparam logic [AW-1:0] PASS_MAX = {AW{1'b1}};

    state_t        state, state_nxt;
    logic [AW-1:0] addr_q, addr_nxt;
    logic [AW-1:0] limit_q, limit_nxt;
    logic          swapped_q, swapped_nxt;
    logic [CW-1:0] cyc_nxt;
    logic [AW-1:0] pass_nxt;
    logic          swap_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            limit_q     <= '0;
            swapped_q   <= 1'b0;
            cycle_count <= '0;
            pass_count  <= '0;
        end else begin
            state       <= state_nxt;
            addr_q      <= addr_nxt;
            limit_q     <= limit_nxt;
            swapped_q   <= swapped_nxt;
            cycle_count <= cyc_nxt;
            pass_count  <= pass_nxt;
        end
    end

    assign dp.addr = addr_q;

    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr_q;
        limit_nxt    = limit_q;
        swapped_nxt  = swapped_q;
        cyc_nxt      = cycle_count;
        pass_nxt     = pass_count;
        dp.in_ready  = 1'b0;
        dp.wr_en     = 1'b0;
        dp.swap_en   = 1'b0;
        dp.out_valid = 1'b0;
        busy         = 1'b0;
        sorting_done = 1'b0;
        // the current cycle's compare result counts toward the early-exit decision
        swap_any     = swapped_q | dp.cmp_gt;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    addr_nxt  = '0;
                    cyc_nxt   = '0;
                    pass_nxt  = '0;
                end
            end

            S_LOAD: begin
                busy        = 1'b1;
                dp.in_ready = 1'b1;
                dp.wr_en    = dp.in_valid;
                if (dp.in_valid) begin
                    if (addr_q == LAST_IDX) begin
                        state_nxt   = S_CMP;
                        addr_nxt    = '0;
                        limit_nxt   = LAST_IDX;
                        swapped_nxt = 1'b0;
                    end else begin
                        addr_nxt = addr_q + 1'b1;
                    end
                end
            end

            S_CMP: begin
                busy       = 1'b1;
                dp.swap_en = dp.cmp_gt;
                if (addr_q == limit_q - 1'b1) begin
                    if (pass_count != PASS_MAX) begin
                        pass_nxt = pass_count + 1'b1;
                    end
                    addr_nxt = '0;
                    if (!swap_any || limit_q == AW'(1)) begin
                        state_nxt = S_UNLOAD;
                    end else begin
                        limit_nxt   = limit_q - 1'b1;
                        swapped_nxt = 1'b0;
                    end
                end else begin
                    addr_nxt    = addr_q + 1'b1;
                    swapped_nxt = swap_any;
                end
            end

            S_UNLOAD: begin
                busy         = 1'b1;
                dp.out_valid = 1'b1;
                if (dp.out_ready) begin
                    if (addr_q == LAST_IDX) begin
                        state_nxt = S_DONE;
                        addr_nxt  = '0;
                    end else begin
                        addr_nxt = addr_q + 1'b1;
                    end
                end
            end

            S_DONE: begin
                sorting_done = 1'b1;
                state_nxt    = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (busy && cycle_count != CYC_MAX) begin
            cyc_nxt = cycle_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_bsort_ctrl.sv
// tb/tb_bsort_ctrl.sv - self-checking bench for bsort_ctrl with register-array datapath models
module tb_bsort_ctrl;

    logic clk;
    logic rst;
    logic start_a, start_b;
    logic busy_a, busy_b;
    logic sorting_done_a, sorting_done_b;
    logic [15:0] cycle_count_a, cycle_count_b;
    logic [3:0]  pass_count_a;
    logic [0:0]  pass_count_b;
    logic [7:0]  din_a, din_b;
    logic [7:0]  mem_a [0:16];
    logic [7:0]  mem_b [0:2];
    logic [7:0]  sb_a [$];
    logic [7:0]  sb_b [$];
    int checks;
    int errors;

    bsort_ctrl_if #(.AW(4)) ifa ();
    bsort_ctrl_if #(.AW(1)) ifb ();

    bsort_ctrl #(.SIZE(15), .AW(4), .CW(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dp(ifa),
        .busy(busy_a), .sorting_done(sorting_done_a),
        .cycle_count(cycle_count_a), .pass_count(pass_count_a)
    );

    bsort_ctrl #(.SIZE(2), .AW(1), .CW(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dp(ifb),
        .busy(busy_b), .sorting_done(sorting_done_b),
        .cycle_count(cycle_count_b), .pass_count(pass_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // datapath models: registered write and swap, combinational compare
    assign ifa.cmp_gt = mem_a[ifa.addr] > mem_a[int'(ifa.addr) + 1];
    assign ifb.cmp_gt = mem_b[ifb.addr] > mem_b[int'(ifb.addr) + 1];

    always @(posedge clk) begin
        if (ifa.wr_en) mem_a[ifa.addr] <= din_a;
        if (ifa.swap_en) begin
            mem_a[ifa.addr]            <= mem_a[int'(ifa.addr) + 1];
            mem_a[int'(ifa.addr) + 1]  <= mem_a[ifa.addr];
        end
        if (ifb.wr_en) mem_b[ifb.addr] <= din_b;
        if (ifb.swap_en) begin
            mem_b[ifb.addr]            <= mem_b[int'(ifb.addr) + 1];
            mem_b[int'(ifb.addr) + 1]  <= mem_b[ifb.addr];
        end
    end

    // Runs one job on the SIZE=15 instance; stream data checked against a sorted scoreboard.
    task automatic run_job_a(input logic [7:0] vals [15], input int vprob, input int rprob,
                             input bit poke_start, output int bcyc, output int ndone);
        int loaded, unloaded;
        bit poked, finished;
        logic [7:0] exp_v;
        loaded = 0; unloaded = 0; bcyc = 0; ndone = 0; poked = 0; finished = 0;
        sb_a.delete();
        @(negedge clk);
        start_a = 1'b1; ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (poke_start && !poked && busy_a && !ifa.in_ready && !ifa.out_valid) begin
                start_a = 1'b1;
                poked = 1;
            end
            ifa.in_valid  = (loaded < 15) && ($urandom_range(0, 99) < vprob);
            din_a         = (loaded < 15) ? vals[loaded] : 8'd0;
            ifa.out_ready = ($urandom_range(0, 99) < rprob);
            #1;
            if (busy_a) bcyc++;
            checks++;
            if ($countones({ifa.wr_en, ifa.swap_en, ifa.out_valid}) > 1) begin
                errors++;
                $display("FAIL strobe_excl: got wr=%0b swap=%0b out=%0b required at most one",
                         ifa.wr_en, ifa.swap_en, ifa.out_valid);
            end
            if (ifa.in_ready) begin
                checks++;
                if (ifa.wr_en !== ifa.in_valid) begin
                    errors++;
                    $display("FAIL load_wr_en: got %0b required %0b", ifa.wr_en, ifa.in_valid);
                end
                checks++;
                if (ifa.addr !== 4'(loaded)) begin
                    errors++;
                    $display("FAIL load_addr: got %0d required %0d", ifa.addr, loaded);
                end
                if (ifa.in_valid) begin
                    sb_a.push_back(din_a);
                    loaded++;
                    if (loaded == 15) sb_a.sort();
                end
            end
            if (ifa.out_valid) begin
                checks++;
                if (ifa.addr !== 4'(unloaded)) begin
                    errors++;
                    $display("FAIL unload_addr: got %0d required %0d", ifa.addr, unloaded);
                end
                if (ifa.out_ready) begin
                    checks++;
                    if (sb_a.size() == 0) begin
                        errors++;
                        $display("FAIL unload_extra: got data %0d required no beat", mem_a[ifa.addr]);
                    end else begin
                        exp_v = sb_a.pop_front();
                        if (mem_a[ifa.addr] !== exp_v) begin
                            errors++;
                            $display("FAIL unload_data: got %0d required %0d", mem_a[ifa.addr], exp_v);
                        end
                    end
                    unloaded++;
                end
            end
            if (sorting_done_a) begin
                ndone++;
                finished = 1;
                checks++;
                if (busy_a !== 1'b0) begin
                    errors++;
                    $display("FAIL done_busy: got %0b required 0", busy_a);
                end
            end
        end
        if (!finished) begin
            checks++; errors++;
            $display("FAIL job_timeout: got no sorting_done required one within 3000 cycles");
        end
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (sorting_done_a !== 1'b0) begin
            errors++;
            $display("FAIL done_width: got %0b required 0 one cycle after pulse", sorting_done_a);
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++;
        if ({busy_a, sorting_done_a, ifa.in_ready, ifa.wr_en, ifa.swap_en, ifa.out_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 000000",
                     {busy_a, sorting_done_a, ifa.in_ready, ifa.wr_en, ifa.swap_en, ifa.out_valid});
        end
        checks++;
        if (ifa.addr !== 4'd0 || cycle_count_a !== 16'd0 || pass_count_a !== 4'd0) begin
            errors++;
            $display("FAIL reset_regs: got addr=%0d cyc=%0d pass=%0d required 0 0 0",
                     ifa.addr, cycle_count_a, pass_count_a);
        end
        checks++;
        if (busy_b !== 1'b0 || ifb.addr !== 1'b0 || cycle_count_b !== 16'd0) begin
            errors++;
            $display("FAIL reset_b: got busy=%0b addr=%0d cyc=%0d required 0 0 0",
                     busy_b, ifb.addr, cycle_count_b);
        end
        rst = 1'b0;
    endtask

    task automatic check_job_a(input string name, input int bc, input int nd,
                               input int exp_cyc, input int exp_pass);
        checks++;
        if (cycle_count_a !== 16'(exp_cyc) || bc != exp_cyc) begin
            errors++;
            $display("FAIL %s_cycles: got %0d (busy seen %0d) required %0d", name, cycle_count_a, bc, exp_cyc);
        end
        checks++;
        if (pass_count_a !== 4'(exp_pass)) begin
            errors++;
            $display("FAIL %s_passes: got %0d required %0d", name, pass_count_a, exp_pass);
        end
        checks++;
        if (nd != 1 || sb_a.size() != 0) begin
            errors++;
            $display("FAIL %s_done: got pulses=%0d left=%0d required 1 0", name, nd, sb_a.size());
        end
    endtask

    task automatic test_presorted();
        logic [7:0] v [15];
        int bc, nd;
        for (int i = 0; i < 15; i++) v[i] = 8'(i + 1);
        run_job_a(v, 100, 100, 0, bc, nd);
        check_job_a("presorted", bc, nd, 44, 1);
    endtask

    task automatic test_reverse();
        logic [7:0] v [15];
        int bc, nd;
        for (int i = 0; i < 15; i++) v[i] = 8'(15 - i);
        run_job_a(v, 100, 100, 0, bc, nd);
        check_job_a("reverse", bc, nd, 135, 14);
    endtask

    task automatic test_backpressure();
        logic [7:0] v [15];
        int bc, nd;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 15; i++) v[i] = 8'($urandom_range(0, 7) * 31);
            run_job_a(v, 55, 50, 0, bc, nd);
            checks++;
            if (cycle_count_a !== 16'(bc) || nd != 1 || sb_a.size() != 0) begin
                errors++;
                $display("FAIL backpressure_job: got cyc=%0d pulses=%0d left=%0d required cyc=%0d 1 0",
                         cycle_count_a, nd, sb_a.size(), bc);
            end
            checks++;
            if (pass_count_a < 4'd1 || pass_count_a > 4'd14) begin
                errors++;
                $display("FAIL backpressure_passes: got %0d required 1..14", pass_count_a);
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [7:0] v [15];
        int bc, nd;
        for (int i = 0; i < 15; i++) v[i] = 8'(15 - i);
        run_job_a(v, 100, 100, 1, bc, nd);
        check_job_a("ignored_start", bc, nd, 135, 14);
    endtask

    task automatic test_reset_mid_job();
        logic [7:0] v [15];
        int bc, nd, ncmp;
        bit hit;
        ncmp = 0; hit = 0;
        @(negedge clk);
        start_a = 1'b1;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
            din_a = 8'(15 - int'(ifa.addr));
            #1;
            if (busy_a && !ifa.in_ready && !ifa.out_valid) ncmp++;
            if (ncmp == 20) hit = 1;
        end
        checks++;
        if (!hit || pass_count_a !== 4'd1) begin
            errors++;
            $display("FAIL midjob_reach: got reached=%0b pass=%0d required 1 1", hit, pass_count_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy_a, sorting_done_a, ifa.in_ready, ifa.wr_en, ifa.swap_en, ifa.out_valid} !== 6'b0 ||
            ifa.addr !== 4'd0 || cycle_count_a !== 16'd0 || pass_count_a !== 4'd0) begin
            errors++;
            $display("FAIL midjob_async_clear: got strobes=%b addr=%0d cyc=%0d pass=%0d required all 0",
                     {busy_a, sorting_done_a, ifa.in_ready, ifa.wr_en, ifa.swap_en, ifa.out_valid},
                     ifa.addr, cycle_count_a, pass_count_a);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++;
            if (sorting_done_a !== 1'b0 || busy_a !== 1'b0) begin
                errors++;
                $display("FAIL midjob_no_done: got done=%0b busy=%0b required 0 0", sorting_done_a, busy_a);
            end
        end
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 15; i++) v[i] = 8'(15 - i);
        run_job_a(v, 100, 100, 0, bc, nd);
        check_job_a("after_reset", bc, nd, 135, 14);
    endtask

    task automatic test_min_size();
        int swaps, cmps, nout;
        bit fin;
        logic [7:0] e;
        swaps = 0; cmps = 0; nout = 0; fin = 0;
        sb_b.delete();
        @(negedge clk);
        start_b = 1'b1;
        for (int c = 0; c < 50 && !fin; c++) begin
            @(negedge clk);
            start_b = 1'b0;
            ifb.in_valid = 1'b1; ifb.out_ready = 1'b1;
            din_b = (ifb.addr == 1'b0) ? 8'd9 : 8'd3;
            #1;
            if (ifb.in_ready && ifb.in_valid) begin
                sb_b.push_back(din_b);
                if (sb_b.size() == 2) sb_b.sort();
            end
            if (busy_b && !ifb.in_ready && !ifb.out_valid) begin
                cmps++;
                if (ifb.swap_en) swaps++;
            end
            if (ifb.out_valid && ifb.out_ready) begin
                nout++;
                checks++;
                e = (sb_b.size() != 0) ? sb_b.pop_front() : 8'hxx;
                if (mem_b[ifb.addr] !== e) begin
                    errors++;
                    $display("FAIL min_data: got %0d required %0d", mem_b[ifb.addr], e);
                end
            end
            if (sorting_done_b) fin = 1;
        end
        ifb.in_valid = 1'b0; ifb.out_ready = 1'b0;
        checks++;
        if (!fin || cmps != 1 || swaps != 1 || nout != 2) begin
            errors++;
            $display("FAIL min_shape: got done=%0b cmp=%0d swap=%0d out=%0d required 1 1 1 2",
                     fin, cmps, swaps, nout);
        end
        checks++;
        if (pass_count_b !== 1'b1 || cycle_count_b !== 16'd5) begin
            errors++;
            $display("FAIL min_counts: got pass=%0d cyc=%0d required 1 5", pass_count_b, cycle_count_b);
        end
    endtask

    task automatic test_back_to_back();
        bit hist [60];
        int dq [$];
        start_b = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            ifb.in_valid = 1'b1; ifb.out_ready = 1'b1;
            din_b = (ifb.addr == 1'b0) ? 8'd9 : 8'd3;
            #1;
            hist[c] = busy_b;
            if (sorting_done_b) dq.push_back(c);
        end
        start_b = 1'b0;
        checks++;
        if (dq.size() < 3) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d required at least 3", dq.size());
        end else begin
            checks++;
            if (dq[1] - dq[0] != 7 || dq[2] - dq[1] != 7) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d,%0d required 7,7", dq[1] - dq[0], dq[2] - dq[1]);
            end
            checks++;
            if (hist[dq[0] + 1] != 1'b0 || hist[dq[0] + 2] != 1'b1) begin
                errors++;
                $display("FAIL b2b_idle_dwell: got busy %0b,%0b required 0,1",
                         hist[dq[0] + 1], hist[dq[0] + 2]);
            end
        end
        for (int c = 0; c < 20 && (busy_b || sorting_done_b); c++) @(negedge clk);
        ifb.in_valid = 1'b0; ifb.out_ready = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        din_a = 8'd0; din_b = 8'd0;
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.out_ready = 1'b0;
        #1 rst = 1'b1;
        test_reset();
        test_presorted();
        test_reverse();
        test_backpressure();
        test_ignored_start();
        test_reset_mid_job();
        test_min_size();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
